// File: rtl/cnt6_dn_timer.sv
// Loadable countdown timer with a built-in divide-by-num tick generator and IDLE/RUN/PAUSE/EXPIRED control.
// Latency: load/start take effect on the next clk edge; tick is combinational; done is registered (1 cycle).
// Backpressure: none; control inputs are sampled every cycle with priority load > start > pause > tick.
module cnt6_dn_timer #(
  parameter int WIDTH = 6,
  parameter int NUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_W-1:0] num,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [NUM_W-1:0] nco_cnt;
  logic [NUM_W-1:0] num_m1;

  // Terminal phase of the tick generator; num of 0 behaves like 1 (tick every cycle).
  always_comb begin
    num_m1 = (num == '0) ? '0 : (num - NUM_ONE);
  end

  // Tick only while running; a num change is picked up at the very next compare.
  always_comb begin
    tick = (state == ST_RUN) && (nco_cnt >= num_m1);
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    busy    = (state == ST_RUN) || (state == ST_PAUSE);
    expired = (state == ST_EXPIRED);
  end

  // Control FSM, countdown register, tick phase and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      out     <= '0;
      nco_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Load aborts anything in flight and never signals done.
        out     <= load_val;
        nco_cnt <= '0;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            nco_cnt <= '0;
            if (start) begin
              if (out != '0) begin
                state <= ST_RUN;
              end else begin
                // Nothing to count: expire immediately without a tick.
                state <= ST_EXPIRED;
                done  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (tick) begin
              nco_cnt <= '0;
              if (out == CNT_ONE) begin
                // Reaching zero wins over a simultaneous pause request.
                out   <= '0;
                state <= ST_EXPIRED;
                done  <= 1'b1;
              end else begin
                out <= out - CNT_ONE;
                if (pause) begin
                  state <= ST_PAUSE;
                end
              end
            end else begin
              // The phase keeps advancing in the cycle pause is seen, so total
              // run time between ticks is always num cycles.
              nco_cnt <= nco_cnt + NUM_ONE;
              if (pause) begin
                state <= ST_PAUSE;
              end
            end
          end
          ST_PAUSE: begin
            // Count and tick phase both frozen; start resumes (beats pause).
            if (start) begin
              state <= ST_RUN;
            end
          end
          ST_EXPIRED: begin
            // Sticky until the next load.
            nco_cnt <= '0;
            out     <= '0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnt6_dn_timer.sv
// Directed bench for the countdown timer: expected vectors go into a scoreboard
// queue as each step is driven and are popped and compared once the DUT has
// responded (1 time unit after the clock edge, or immediately for async reset).
module tb_cnt6_dn_timer;

  logic        clk;
  logic        rst_n;
  logic [31:0] num;
  logic        load;
  logic [5:0]  load_val;
  logic        start;
  logic        pause;
  logic [5:0]  out;
  logic        tick;
  logic        busy;
  logic        expired;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [5:0] out;
    logic       tick;
    logic       busy;
    logic       expired;
    logic       done;
  } exp_t;

  exp_t sb[$];

  cnt6_dn_timer #(.WIDTH(6), .NUM_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .num      (num),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .out      (out),
    .tick     (tick),
    .busy     (busy),
    .expired  (expired),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [5:0] o, input logic t,
                      input logic b, input logic e, input logic d);
    exp_t x;
    x.tag = tag; x.out = o; x.tick = t; x.busy = b; x.expired = e; x.done = d;
    sb.push_back(x);
  endtask

  // Pops every pending expectation and compares {out,tick,busy,expired,done}.
  task automatic check();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      vectors++;
      assert ({out, tick, busy, expired, done} === {x.out, x.tick, x.busy, x.expired, x.done})
      else begin
        miscompares++;
        $error("FAIL %s: got out=%0d tick=%b busy=%b expired=%b done=%b, want out=%0d tick=%b busy=%b expired=%b done=%b",
               x.tag, out, tick, busy, expired, done,
               x.out, x.tick, x.busy, x.expired, x.done);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive is already applied; record the expectation, clock once, then compare.
  task automatic step(input string tag, input logic [5:0] o, input logic t,
                      input logic b, input logic e, input logic d);
    push(tag, o, t, b, e, d);
    cyc();
    check();
  endtask

  initial begin
    rst_n = 1'b0; num = 32'd4; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;
    cyc(); cyc();
    push("reset_state", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    rst_n = 1'b1;
    cyc();

    // Test 2: num=4, count 3 -> 0 with ticks every 4 cycles after RUN entry.
    num = 32'd4; load = 1'b1; load_val = 6'd3;
    step("t2_load", 6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step("t2_run_entry", 6'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k < 12)
        step($sformatf("t2_k%0d", k), 6'(3 - k / 4), (k % 4) == 3, 1'b1, 1'b0, 1'b0);
      else
        step("t2_expire", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    step("t2_done_drop", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1; pause = 1'b1;
    step("t2_exp_ignores_start", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0; pause = 1'b0;

    // Test 3: pause with phase 2 of 4 for 20 cycles, resume keeps the phase.
    load = 1'b1; load_val = 6'd10;
    step("t3_load", 6'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step("t3_run_entry", 6'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 9; k++)
      step($sformatf("t3_k%0d", k), 6'(10 - k / 4), (k % 4) == 3, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    for (int k = 0; k < 20; k++)
      step($sformatf("t3_paused%0d", k), 6'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    pause = 1'b0; start = 1'b1;
    step("t3_resume", 6'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t3_resume_tick", 6'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step("t3_after_tick", 6'd7, 1'b0, 1'b1, 1'b0, 1'b0);

    // Test 4: load 0 then start expires at once, no tick.
    load = 1'b1; load_val = 6'd0;
    step("t4_load0", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step("t4_expire", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step("t4_hold", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Test 5: tick and pause together at out=1 -> expiry beats pause.
    num = 32'd2; load = 1'b1; load_val = 6'd1;
    step("t5_load", 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step("t5_run_entry", 6'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t5_tick_up", 6'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    step("t5_expire_not_pause", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    pause = 1'b0;

    // Test 6: load + start while running -> reload, IDLE, no done.
    num = 32'd4; load = 1'b1; load_val = 6'd7;
    step("t6_load7", 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step("t6_run", 6'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    load = 1'b1; start = 1'b1; load_val = 6'd20;
    step("t6_load_beats_start", 6'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b0;
    step("t6_idle_hold", 6'd20, 1'b0, 1'b0, 1'b0, 1'b0);

    // num=0 behaves as 1: decrement every cycle.
    num = 32'd0; start = 1'b1;
    step("num0_run_entry", 6'd20, 1'b1, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 5; k++)
      step($sformatf("num0_k%0d", k), 6'(20 - k), 1'b1, 1'b1, 1'b0, 1'b0);

    // Test 1: async reset mid-run at out=5 clears before any edge.
    num = 32'd4; load = 1'b1; load_val = 6'd5;
    step("t1_load5", 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step("t1_run", 6'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t1_run2", 6'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    push("t1_async_reset", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    cyc();
    rst_n = 1'b1;
    step("t1_after_release", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
